rpn_sequencer: RTL and testbench

- Upstream feeder for the operand/operator stack datapath.
- Holds a small writable program of RPN tokens and, on start, issues one token per cycle on num/op/x.
- Tracks stack depth so it can stop the run before an underflow or overflow reaches the stack.
- At the end of a run, captures the stack top (qtop) as the result and reports done or err.

---
 rtl/rpn_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rpn_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_sequencer.sv
// rpn_sequencer
//   Feeds RPN tokens, one per cycle, from a small writable program into the
//   operand/operator stack datapath. It tracks stack depth so that a run stops
//   (ERR) before an underflow or overflow reaches the stack. At the end of a
//   successful run it captures the stack top as the result.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   reset   : synchronous active-high reset
//   we      : program write enable (honoured only in IDLE)
//   waddr   : program write address
//   wdata   : token, [17:16] kind (00 NUM, 01 OP, 10 END, 11 NOP), [15:0] value
//   start   : begin a run from address 0 (honoured in IDLE, DONE, ERR)
//   qtop    : current stack top fed back from the stack
//   num     : push x this cycle
//   op      : apply ALU function x[4:0] this cycle
//   x       : token value, held when num = op = 0
//   result  : qtop captured at the end of a successful run
//   depth   : tracked stack depth
//   busy    : high in RUN or DRAIN
//   done    : high in DONE
//   err     : high in ERR
module rpn_sequencer #(
  parameter int AW     = 4,
  parameter int SDEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [17:0]   wdata,
  input  logic          start,
  input  logic [15:0]   qtop,
  output logic          num,
  output logic          op,
  output logic [15:0]   x,
  output logic [15:0]   result,
  output logic [3:0]    depth,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0]    K_NUM    = 2'b00;
  localparam logic [1:0]    K_OP     = 2'b01;
  localparam logic [1:0]    K_END    = 2'b10;
  localparam logic [AW-1:0] LAST     = '1;
  localparam logic [3:0]    SDEPTH_L = 4'(SDEPTH);

  state_t          state;
  logic [AW-1:0]   pc;
  logic [17:0]     mem [2**AW];

  logic [17:0]     tok;
  logic [1:0]      kind;
  logic [15:0]     val;
  logic            is_end;

  // Asynchronous fetch; the last slot is forced to END so a run always ends.
  assign tok    = mem[pc];
  assign kind   = tok[17:16];
  assign val    = tok[15:0];
  assign is_end = (pc == LAST) || (kind == K_END);

  // Program store: data only, never reset.
  always_ff @(posedge clk) begin
    if (we && state == S_IDLE) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      num    <= 1'b0;
      op     <= 1'b0;
      x      <= '0;
      result <= '0;
      depth  <= '0;
      pc     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      num <= 1'b0;
      op  <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_RUN;
            pc    <= '0;
            depth <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end

        S_RUN: begin
          if (is_end) begin
            // An empty stack at END has no result to report.
            if (depth == 4'd0) begin
              state <= S_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (kind == K_NUM) begin
            if (depth == SDEPTH_L) begin
              state <= S_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              num   <= 1'b1;
              x     <= val;
              depth <= depth + 4'd1;
              pc    <= pc + 1'b1;
            end
          end else if (kind == K_OP) begin
            // value[4] selects unary (needs 1 operand) vs binary (needs 2).
            if (depth < (val[4] ? 4'd1 : 4'd2)) begin
              state <= S_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              op    <= 1'b1;
              x     <= val;
              depth <= val[4] ? depth : depth - 4'd1;
              pc    <= pc + 1'b1;
            end
          end else begin
            pc <= pc + 1'b1;
          end
        end

        // One spare cycle lets the stack absorb the last issued token
        // before its top is captured.
        S_DRAIN: begin
          result <= qtop;
          state  <= S_DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
module tb_rpn_sequencer;

  localparam int AW     = 4;
  localparam int SDEPTH = 8;
  localparam int NADDR  = 2**AW;

  localparam logic [17:0] TE = {2'b10, 16'h0000};
  localparam logic [17:0] TP = {2'b11, 16'h0000};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [17:0]   wdata = '0;
  logic          start = 1'b0;
  logic [15:0]   qtop;
  logic          num, op;
  logic [15:0]   x, result;
  logic [3:0]    depth;
  logic          busy, done, err;

  rpn_sequencer #(.AW(AW), .SDEPTH(SDEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .start(start), .qtop(qtop), .num(num), .op(op), .x(x), .result(result),
    .depth(depth), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] tN(input logic [15:0] v);
    return {2'b00, v};
  endfunction
  function automatic logic [17:0] tO(input logic [4:0] f);
    return {2'b01, 11'h0, f};
  endfunction

  // Stack environment: absorbs the token issued in the previous cycle.
  logic [15:0] stk [16];
  int          sp = 0;
  assign qtop = (sp > 0) ? stk[sp-1] : 16'h0;

  always @(posedge clk) begin
    logic [15:0] t [16];
    int s;
    t = stk;
    s = sp;
    if (start) s = 0;
    if (num && s < 16) begin
      t[s] = x;
      s++;
    end else if (op) begin
      if (x[4]) begin
        if (s >= 1) t[s-1] = -t[s-1];
      end else if (s >= 2) begin
        t[s-2] = (x[4:0] == 5'd1) ? t[s-2] - t[s-1] : t[s-2] + t[s-1];
        s--;
      end
    end
    stk <= t;
    sp  <= s;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Bench copy of the program and the reference evaluation of it.
  logic [17:0] prog [NADDR];
  bit          m_err;
  logic [15:0] m_res;
  int          m_dep, m_cyc;
  logic [15:0] m_iss [$];

  task automatic model();
    logic [15:0] s [$];
    logic [17:0] tk;
    logic [15:0] a, b;
    m_iss.delete();
    m_err = 0; m_res = 0; m_cyc = 0;
    for (int i = 0; i < NADDR; i++) begin
      tk = (i == NADDR-1) ? TE : prog[i];
      if (tk[17:16] == 2'b10) begin
        if (s.size() == 0) begin m_err = 1; m_cyc = i + 1; end
        else begin m_res = s[$]; m_cyc = i + 2; end
        break;
      end else if (tk[17:16] == 2'b00) begin
        if (s.size() == SDEPTH) begin m_err = 1; m_cyc = i + 1; break; end
        s.push_back(tk[15:0]);
        m_iss.push_back(tk[15:0]);
      end else if (tk[17:16] == 2'b01) begin
        if (tk[4]) begin
          if (s.size() < 1) begin m_err = 1; m_cyc = i + 1; break; end
          s[$] = -s[$];
        end else begin
          if (s.size() < 2) begin m_err = 1; m_cyc = i + 1; break; end
          b = s.pop_back();
          a = s.pop_back();
          s.push_back((tk[4:0] == 5'd1) ? a - b : a + b);
        end
        m_iss.push_back(tk[15:0]);
      end
    end
    m_dep = s.size();
  endtask

  // Reset (program survives) and write the whole bench program.
  task automatic load();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    for (int a = 0; a < NADDR; a++) begin
      we = 1'b1; waddr = AW'(a); wdata = prog[a];
      @(negedge clk);
    end
    we = 1'b0;
  endtask

  int r_k, r_nums, r_ops;

  task automatic run(input string nm, input bit wr, input logic [AW-1:0] wa,
                     input logic [17:0] wd);
    int idx;
    model();
    @(negedge clk);
    start = 1'b1; we = wr; waddr = wa; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; we = 1'b0;
    check({nm, " busy"}, busy, 1);
    r_k = 0; r_nums = 0; r_ops = 0; idx = 0;
    while (!(done || err) && r_k < 200) begin
      @(posedge clk); #1;
      r_k++;
      if (num && op) check({nm, " num&op"}, {num, op}, 2'b00);
      if (num || op) begin
        if (num) r_nums++;
        if (op) r_ops++;
        if (idx < m_iss.size()) check({nm, " x"}, x, m_iss[idx]);
        idx++;
      end
    end
    if (r_k >= 200) check({nm, " timeout"}, 0, 1);
    check({nm, " err"}, err, m_err);
    check({nm, " done"}, done, !m_err);
    check({nm, " cycles"}, r_k, m_cyc);
    check({nm, " depth"}, depth, m_dep);
    check({nm, " issued"}, idx, m_iss.size());
    if (!m_err) check({nm, " result"}, result, m_res);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [17:0] tk [10];
    bit          e;
    logic [15:0] res;
    int          dep;
    int          cyc;
    int          nn;
    int          no;
  } vec_t;

  vec_t v [9];

  initial begin
    v[0] = '{"add",    4, '{tN(3), tN(4), tO(0), TE, TP, TP, TP, TP, TP, TP}, 0, 16'd7,    1, 5,  2, 1};
    v[1] = '{"neg",    4, '{tN(5), tO(5'h10), TP, TE, TP, TP, TP, TP, TP, TP}, 0, 16'hFFFB, 1, 5,  1, 1};
    v[2] = '{"under2", 2, '{tN(1), tO(0), TP, TP, TP, TP, TP, TP, TP, TP}, 1, 16'd0,    1, 2,  1, 0};
    v[3] = '{"over",   9, '{tN(1), tN(2), tN(3), tN(4), tN(5), tN(6), tN(7), tN(8), tN(9), TP},
             1, 16'd0, 8, 9, 8, 0};
    v[4] = '{"end0",   1, '{TE, TP, TP, TP, TP, TP, TP, TP, TP, TP}, 1, 16'd0, 0, 1, 0, 0};
    v[5] = '{"allnop", 0, '{TP, TP, TP, TP, TP, TP, TP, TP, TP, TP}, 1, 16'd0, 0, 16, 0, 0};
    v[6] = '{"nop9",   8, '{TP, TP, TP, TP, TP, TP, TP, tN(9), TP, TP}, 0, 16'd9, 1, 17, 1, 0};
    v[7] = '{"sub",    4, '{tN(10), tN(3), tO(1), TE, TP, TP, TP, TP, TP, TP}, 0, 16'd7, 1, 5, 2, 1};
    v[8] = '{"under1", 1, '{tO(5'h10), TP, TP, TP, TP, TP, TP, TP, TP, TP}, 1, 16'd0, 0, 1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst num", num, 0);
    check("rst op", op, 0);
    check("rst x", x, 0);
    check("rst result", result, 0);
    check("rst depth", depth, 0);
    check("rst flags", {busy, done, err}, 3'b000);

    // Table-driven programs
    for (int i = 0; i < 9; i++) begin
      for (int a = 0; a < NADDR; a++) prog[a] = (a < v[i].n) ? v[i].tk[a] : TP;
      load();
      run(v[i].name, 0, '0, '0);
      check({v[i].name, " t.err"}, err, v[i].e);
      check({v[i].name, " t.depth"}, depth, v[i].dep);
      check({v[i].name, " t.cycles"}, r_k, v[i].cyc);
      check({v[i].name, " t.nums"}, r_nums, v[i].nn);
      check({v[i].name, " t.ops"}, r_ops, v[i].no);
      if (!v[i].e) check({v[i].name, " t.result"}, result, v[i].res);
      // Rerun straight from DONE/ERR
      if (i == 2 || i == 0) begin
        run({v[i].name, "-rerun"}, 0, '0, '0);
      end
    end

    // Reset two cycles into a run aborts; program is retained
    for (int a = 0; a < NADDR; a++) prog[a] = (a < 4) ? v[0].tk[a] : TP;
    load();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort num", num, 0);
    check("abort op", op, 0);
    check("abort flags", {busy, done, err}, 3'b000);
    check("abort depth", depth, 0);
    @(negedge clk) reset = 1'b0;
    run("after-abort", 0, '0, '0);
    check("after-abort result", result, 16'd7);

    // Writes outside IDLE are dropped
    @(negedge clk);
    we = 1'b1; waddr = '0; wdata = tN(100);
    @(negedge clk) we = 1'b0;
    run("we-ignored", 0, '0, '0);
    check("we-ignored result", result, 16'd7);

    // Write and start in the same IDLE cycle: the write is fetched first
    for (int a = 0; a < NADDR; a++) prog[a] = TE;
    load();
    prog[0] = tN(6);
    run("wr+start", 1, '0, tN(6));
    check("wr+start result", result, 16'd6);

    // Random programs against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int a = 0; a < NADDR; a++) begin
        int k;
        k = $urandom_range(0, 9);
        if (k < 4)       prog[a] = tN(16'($urandom));
        else if (k < 7)  prog[a] = tO((k == 4) ? 5'd0 : (k == 5) ? 5'd1 : 5'h10);
        else if (k == 7) prog[a] = TE;
        else             prog[a] = TP;
      end
      load();
      run($sformatf("rand%0d", r), 0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
